// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  // The memory returns all zeros past the end of the program.
  localparam logic [31:0] END_MARKER = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries. Pointers carry an extra wrap bit so
// full and empty are distinguished without a counter. Flush beats push.
// The head output holds the last popped entry while the FIFO is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  fetch_entry_t r_mem [DEPTH];
  fetch_entry_t r_last;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  // A full FIFO may still accept a write when the head leaves this cycle.
  assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_rdata = w_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update: reset and flush both return to an empty FIFO.
  always_ff @(posedge clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  // Remember the most recently consumed head so it stays visible when empty.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_last <= '0;
    end else if (w_do_pop) begin
      r_last <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, addresses the combinational
// instruction memory, and buffers fetched words for decode. Stops on the
// end-of-program marker and restarts on redirects.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;

  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_fetch_go;
  logic         w_hit_end;
  logic         w_push;
  logic         w_halted;
  fetch_entry_t w_wdata;
  fetch_entry_t w_head;

  assign w_pop = !w_empty && instr_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; a redirect restarts fetching from any state.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (run) w_next_state = FETCH;
      FETCH:   if (w_hit_end) w_next_state = HALT;
      HALT:    w_next_state = HALT;
      default: w_next_state = IDLE;
    endcase
    if (redirect_valid) w_next_state = FETCH;
  end

  // Output/control decode for the current state.
  always_comb begin
    w_fetch_go = 1'b0;
    w_hit_end  = 1'b0;
    w_push     = 1'b0;
    w_halted   = 1'b0;
    case (r_state)
      FETCH: begin
        w_fetch_go = run && (!w_full || w_pop);
        w_hit_end  = w_fetch_go && (imem_rdata == END_MARKER);
        // Words fetched in a redirect cycle belong to the abandoned path.
        w_push     = w_fetch_go && !w_hit_end && !redirect_valid;
      end
      HALT:    w_halted = 1'b1;
      default: ;
    endcase
  end

  // PC register: the end marker leaves the PC parked on the marker address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= align_pc(redirect_pc);
    end else if (w_push) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  assign w_wdata.pc    = r_pc;
  assign w_wdata.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_reset (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign imem_addr   = r_pc;
  assign instr_valid = !w_empty;
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign halted      = w_halted;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Testbench for instr_fetch_ctrl: a ROM model feeds the DUT, a scoreboard
// queue holds the program-order words decode should receive, and directed
// checks cover latency, back-pressure, halting, redirects and reset.
module tb_instr_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  logic [31:0]  rom [64];
  fetch_entry_t sb_q [$];
  fetch_entry_t sb_e;
  int checks   = 0;
  int failures = 0;
  int n_hs     = 0;
  int hs_before;

  assign imem_rdata = rom[imem_addr[7:2]];

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected stream: program order from start until the end marker.
  task automatic sb_load(input logic [31:0] start);
    logic [31:0]  a;
    fetch_entry_t e;
    a = start;
    sb_q.delete();
    for (int i = 0; i < 64; i++) begin
      if (rom[a[7:2]] == 32'h0) break;
      e.pc    = a;
      e.instr = rom[a[7:2]];
      sb_q.push_back(e);
      a = a + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: handshakes pop the queue, redirects/reset reload it.
  always @(negedge clk) begin
    if (reset) begin
      sb_load(RESET_PC);
    end else begin
      if (instr_valid && instr_ready) begin
        n_hs++;
        if (sb_q.size() == 0) begin
          chk("sb_extra", 32'(instr_valid), 32'd0);
        end else begin
          sb_e = sb_q.pop_front();
          chk("sb_pc", instr_pc, sb_e.pc);
          chk("sb_instr", instr, sb_e.instr);
        end
      end
      if (redirect_valid) sb_load({redirect_pc[31:2], 2'b00});
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = {8'hC0, 8'(i), 16'h0013};
    rom[0]  = 32'h0000_0013;
    rom[1]  = 32'h0000_0093;
    rom[14] = 32'h0010_0293;
    rom[20] = 32'h0401_0E63;
    rom[25] = 32'h0203_0063;
    rom[43] = 32'h0000_0000;

    reset = 1'b1; run = 1'b0; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and IDLE hold while run=0.
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    step(); step();
    chk("idle_addr", imem_addr, RESET_PC);
    chk("idle_valid", 32'(instr_valid), 32'd0);

    // Test 1: streaming at one instruction per cycle.
    run = 1'b1;
    step();
    chk("t1_fetch_valid", 32'(instr_valid), 32'd0);
    step();
    chk("t1_first_valid", 32'(instr_valid), 32'd1);
    chk("t1_first_pc", instr_pc, 32'h0);
    chk("t1_first_instr", instr, 32'h0000_0013);
    for (int k = 1; k <= 14; k++) begin
      step();
      chk("t1_stream_pc", instr_pc, 32'(4 * k));
      if (k == 1)  chk("t1_instr1", instr, 32'h0000_0093);
      if (k == 14) chk("t1_instr14", instr, 32'h0010_0293);
    end

    // Test 2: back-pressure fills the FIFO and stalls the PC.
    reset = 1'b1; instr_ready = 1'b0;
    step();
    reset = 1'b0;
    repeat (5) step();
    chk("t2_addr_stall", imem_addr, RESET_PC + 32'd8);
    chk("t2_head_pc", instr_pc, RESET_PC);
    chk("t2_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    step();
    chk("t2_drain_pc", instr_pc, 32'h4);
    chk("t2_full_pop_push", imem_addr, 32'hC);

    // Test 3: run into the end marker, then redirect out of HALT.
    begin
      int n;
      n = 0;
      while (!halted && n < 200) begin
        step();
        n++;
      end
    end
    chk("t3_halted", 32'(halted), 32'd1);
    chk("t3_addr_end", imem_addr, 32'hAC);
    step();
    chk("t3_drained", 32'(instr_valid), 32'd0);
    chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h50;
    step();
    redirect_valid = 1'b0;
    chk("t3_unhalt", 32'(halted), 32'd0);
    chk("t3_flush_valid", 32'(instr_valid), 32'd0);
    chk("t3_redir_addr", imem_addr, 32'h50);
    step();
    chk("t3_head_valid", 32'(instr_valid), 32'd1);
    chk("t3_head_pc", instr_pc, 32'h50);
    chk("t3_head_instr", instr, 32'h0401_0E63);

    // Test 4: unaligned redirect while the FIFO is full.
    instr_ready = 1'b0;
    repeat (3) step();
    chk("t4_full_valid", 32'(instr_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h66;
    step();
    redirect_valid = 1'b0;
    chk("t4_flush_valid", 32'(instr_valid), 32'd0);
    chk("t4_addr", imem_addr, 32'h64);
    step();
    chk("t4_head_pc", instr_pc, 32'h64);
    chk("t4_head_instr", instr, 32'h0203_0063);
    step();

    // Test 5: redirect and pop together, landing near the top of memory
    // so the PC wraps to zero.
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9;
    hs_before = n_hs;
    step();
    redirect_valid = 1'b0;
    chk("t5_pop_once", 32'(n_hs - hs_before), 32'd1);
    chk("t5_flush_valid", 32'(instr_valid), 32'd0);
    chk("t5_addr", imem_addr, 32'hFFFF_FFF8);
    step();
    chk("t5_head0", instr_pc, 32'hFFFF_FFF8);
    step();
    chk("t5_head1", instr_pc, 32'hFFFF_FFFC);
    step();
    chk("t5_wrap", instr_pc, 32'h0);

    // Test 6: reset with two words buffered drops them.
    instr_ready = 1'b0;
    repeat (3) step();
    chk("t6_full_valid", 32'(instr_valid), 32'd1);
    reset = 1'b1; run = 1'b0;
    step();
    reset = 1'b0;
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_addr", imem_addr, RESET_PC);
    chk("t6_halted", 32'(halted), 32'd0);
    chk("t6_instr", instr, 32'h0);
    repeat (3) step();
    chk("t6_idle_addr", imem_addr, RESET_PC);
    chk("t6_idle_valid", 32'(instr_valid), 32'd0);
    run = 1'b1; instr_ready = 1'b1;
    step(); step();
    chk("t6_restart_valid", 32'(instr_valid), 32'd1);
    chk("t6_restart_pc", instr_pc, RESET_PC);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
